// File: rtl/inst_rom.sv
// ---------------------------------------------------------------------------
// inst_rom
//   Loadable instruction memory sitting between a program loader and a core.
//   A loader streams words in through a valid/ready handshake. While a program
//   is being loaded, the core is held in reset. Once the program is complete,
//   the core is released and may fetch words through a zero-latency read port.
//
// Parameters
//   DEPTH     number of 32-bit instruction words (power of two)
//   AW        word-index width, log2(DEPTH)
//   NOP_INST  word returned whenever no valid word can be fetched
//
// Ports
//   clk           sole clock, rising edge
//   rst           asynchronous active-high reset
//   inst_addr_i   byte address of the core's fetch
//   inst_o        fetched instruction (combinational)
//   load_start_i  pulse: abandon the current program and start a new load
//   load_valid_i  loader presents a word on load_data_i
//   load_data_i   program word
//   load_last_i   final word of the program (qualified by load_valid_i)
//   load_ready_o  block accepts a load word this cycle
//   core_rst_o    holds the core in reset until a program is runnable
//   load_done_o   one-cycle pulse after the program becomes runnable
//   word_cnt_o    number of words currently loaded
//   err_o         sticky flag for misaligned or out-of-range fetches
// ---------------------------------------------------------------------------
module inst_rom #(
  parameter int          DEPTH    = 4096,
  parameter int          AW       = 12,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   inst_addr_i,
  output logic [31:0]   inst_o,
  input  logic          load_start_i,
  input  logic          load_valid_i,
  input  logic [31:0]   load_data_i,
  input  logic          load_last_i,
  output logic          load_ready_o,
  output logic          core_rst_o,
  output logic          load_done_o,
  output logic [AW:0]   word_cnt_o,
  output logic          err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Index of the final storage slot; writing it fills the memory.
  localparam logic [AW:0] LAST_IDX = (AW + 1)'(DEPTH - 1);

  state_t         state;
  logic [31:0]    mem [DEPTH];

  logic           transfer;
  logic [AW-1:0]  idx;
  logic           aligned;
  logic           upper_zero;
  logic           in_range;
  logic           fetch_ok;

  // The loader may only push words while no program is running.
  always_comb begin
    load_ready_o = (state != RUN);
  end

  // A start pulse beats a coincident word: that word is dropped uncounted.
  always_comb begin
    transfer = load_valid_i && load_ready_o && !load_start_i;
  end

  // Fetch qualification: the address must be word aligned, must not carry
  // bits above the index field, and must point at a word that was loaded.
  always_comb begin
    idx        = inst_addr_i[AW+1:2];
    aligned    = (inst_addr_i[1:0] == 2'b00);
    upper_zero = ((inst_addr_i >> (AW + 2)) == 32'd0);
    in_range   = ({1'b0, idx} < word_cnt_o);
    fetch_ok   = (state == RUN) && aligned && upper_zero && in_range;
  end

  // Zero-latency read; anything not provably valid becomes a NOP, so stale
  // words from an earlier program can never leak out.
  always_comb begin
    inst_o = NOP_INST;
    if (fetch_ok) begin
      inst_o = mem[idx];
    end
  end

  // Storage is deliberately not reset: word_cnt_o alone decides which
  // entries are live.
  always_ff @(posedge clk) begin
    if (transfer) begin
      mem[word_cnt_o[AW-1:0]] <= load_data_i;
    end
  end

  // Control FSM. core_rst_o, load_done_o and err_o are registered alongside
  // the state so they change on the same edge as the state transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      word_cnt_o  <= '0;
      core_rst_o  <= 1'b1;
      load_done_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      load_done_o <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (load_start_i) begin
            state      <= IDLE;
            word_cnt_o <= '0;
            core_rst_o <= 1'b1;
          end else if (transfer) begin
            word_cnt_o <= word_cnt_o + (AW + 1)'(1);
            // Either the loader marks the end or the memory fills up.
            if (load_last_i || (word_cnt_o == LAST_IDX)) begin
              state       <= RUN;
              core_rst_o  <= 1'b0;
              load_done_o <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        RUN: begin
          if (load_start_i) begin
            state      <= IDLE;
            word_cnt_o <= '0;
            core_rst_o <= 1'b1;
            err_o      <= 1'b0;
          end else if (!fetch_ok) begin
            err_o <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          word_cnt_o <= '0;
          core_rst_o <= 1'b1;
          err_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule
